// File: rtl/bnn_stream_core.sv
// Two-layer binary neural network (XNOR-popcount + threshold) with valid/ready streaming
// and a nibble-serial runtime configuration port for all weights and thresholds.
module bnn_stream_core #(
  parameter int IN_W  = 8,
  parameter int N_HID = 4,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  input  logic             cfg_en,
  input  logic [3:0]       cfg_nib,
  output logic             cfg_done,
  output logic             busy
);

  localparam int TW1     = $clog2(IN_W + 1);
  localparam int TW2     = $clog2(N_HID + 1);
  localparam int WN1     = (IN_W + 3) / 4;
  localparam int WN2     = (N_HID + 3) / 4;
  localparam int TN1     = (TW1 + 3) / 4;
  localparam int TN2     = (TW2 + 3) / 4;
  localparam int REC1    = WN1 + TN1;
  localparam int REC2    = WN2 + TN2;
  localparam int REC_MAX = (REC1 > REC2) ? REC1 : REC2;
  localparam int SH_W    = 4 * REC_MAX;
  localparam int N_NEU   = N_HID + N_OUT;
  localparam int NIB_W   = $clog2(REC_MAX + 1);
  localparam int NEU_W   = $clog2(N_NEU);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_L1, S_L2, S_OUT} state_e;

  state_e               state_q, state_d;
  logic [NIB_W-1:0]     nib_q, nib_d;
  logic [NEU_W-1:0]     neu_q, neu_d;
  logic [SH_W-1:0]      shadow_q, rec_full;
  logic                 cfg_done_q;
  logic [IN_W-1:0]      in_q;
  logic [N_HID-1:0]     hid_q, hid_d;
  logic [N_OUT-1:0]     out_q, out_d;

  logic [IN_W-1:0]      w1_q [N_HID];
  logic [TW1-1:0]       t1_q [N_HID];
  logic [N_HID-1:0]     w2_q [N_OUT];
  logic [TW2-1:0]       t2_q [N_OUT];

  logic in_l2, rec_last, cfg_last, cfg_take, accept;

  function automatic logic [TW1-1:0] pop1(input logic [IN_W-1:0] v);
    logic [TW1-1:0] c;
    c = '0;
    for (int i = 0; i < IN_W; i++) c = c + TW1'(v[i]);
    return c;
  endfunction

  function automatic logic [TW2-1:0] pop2(input logic [N_HID-1:0] v);
    logic [TW2-1:0] c;
    c = '0;
    for (int i = 0; i < N_HID; i++) c = c + TW2'(v[i]);
    return c;
  endfunction

  assign in_l2    = (neu_q >= NEU_W'(N_HID));
  assign rec_last = in_l2 ? (nib_q == NIB_W'(REC2 - 1)) : (nib_q == NIB_W'(REC1 - 1));
  assign cfg_last = rec_last && (neu_q == NEU_W'(N_NEU - 1));
  // The nibble presented on the IDLE->CFG edge is the first nibble of the stream.
  assign cfg_take = cfg_en && ((state_q == S_IDLE) || (state_q == S_CFG));
  assign in_ready = (state_q == S_IDLE) && !cfg_en;
  assign accept   = in_valid && in_ready;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rec_full = shadow_q;
    rec_full[4*nib_q +: 4] = cfg_nib;
  end

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    neu_d   = neu_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_en)      state_d = cfg_last ? S_IDLE : S_CFG;
        else if (accept) state_d = S_L1;
      end
      S_CFG:   if (cfg_en && cfg_last) state_d = S_IDLE;
      S_L1:    state_d = S_L2;
      S_L2:    state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cfg_take) begin
      if (cfg_last) begin
        nib_d = '0;
        neu_d = '0;
      end else if (rec_last) begin
        nib_d = '0;
        neu_d = neu_q + NEU_W'(1);
      end else begin
        nib_d = nib_q + NIB_W'(1);
      end
    end
  end

  always_comb begin
    hid_d = '0;
    out_d = '0;
    for (int n = 0; n < N_HID; n++) hid_d[n] = (pop1(~(in_q ^ w1_q[n])) >= t1_q[n]);
    for (int k = 0; k < N_OUT; k++) out_d[k] = (pop2(~(hid_q ^ w2_q[k])) >= t2_q[k]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nib_q      <= '0;
      neu_q      <= '0;
      shadow_q   <= '0;
      cfg_done_q <= 1'b0;
      in_q       <= '0;
      hid_q      <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      neu_q      <= neu_d;
      cfg_done_q <= cfg_take && cfg_last;
      if (cfg_take)          shadow_q <= rec_full;
      if (accept)            in_q     <= in_data;
      if (state_q == S_L1)   hid_q    <= hid_d;
      if (state_q == S_L2)   out_q    <= out_d;
    end
  end

  // NOTE: the weight/threshold arrays are reset explicitly: a reset must leave every neuron firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_HID; n++) begin
        w1_q[n] <= '0;
        t1_q[n] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) begin
        w2_q[k] <= '0;
        t2_q[k] <= '0;
      end
    end else if (cfg_take && rec_last) begin
      // Weight and threshold commit together from the completed record.
      for (int n = 0; n < N_HID; n++) begin
        if (neu_q == NEU_W'(n)) begin
          w1_q[n] <= rec_full[IN_W-1:0];
          t1_q[n] <= rec_full[4*WN1 +: TW1];
        end
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (neu_q == NEU_W'(N_HID + k)) begin
          w2_q[k] <= rec_full[N_HID-1:0];
          t2_q[k] <= rec_full[4*WN2 +: TW2];
        end
      end
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bnn_stream_core.sv
// Scoreboard bench for bnn_stream_core: randomized vectors and configs against a
// popcount/threshold reference model; a monitor pops expected outputs on each handshake.
module tb_bnn_stream_core;

  localparam int IN_W  = 8;
  localparam int N_HID = 4;
  localparam int N_OUT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [IN_W-1:0]  in_data;
  logic [N_OUT-1:0] out_data;
  logic             cfg_en, cfg_done, busy;
  logic [3:0]       cfg_nib;

  bnn_stream_core #(.IN_W(IN_W), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_en(cfg_en), .cfg_nib(cfg_nib), .cfg_done(cfg_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N_OUT-1:0] exp_q[$];
  logic [3:0]       stream[$];

  // Reference model state (active) and pending config (being streamed).
  logic [IN_W-1:0]  m_w1 [N_HID];
  int               m_t1 [N_HID];
  logic [N_HID-1:0] m_w2 [N_OUT];
  int               m_t2 [N_OUT];
  logic [IN_W-1:0]  p_w1 [N_HID];
  logic [3:0]       p_t1 [N_HID];
  logic [N_HID-1:0] p_w2 [N_OUT];
  logic [3:0]       p_t2 [N_OUT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_OUT-1:0] model_out(input logic [IN_W-1:0] x);
    logic [N_HID-1:0] h;
    logic [N_OUT-1:0] o;
    for (int n = 0; n < N_HID; n++) h[n] = ($countones(~(x ^ m_w1[n])) >= m_t1[n]);
    for (int k = 0; k < N_OUT; k++) o[k] = ($countones(~(h ^ m_w2[k])) >= m_t2[k]);
    return o;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N_HID; n++) begin m_w1[n] = '0; m_t1[n] = 0; end
    for (int k = 0; k < N_OUT; k++) begin m_w2[k] = '0; m_t2[k] = 0; end
  endtask

  task automatic model_commit();
    for (int n = 0; n < N_HID; n++) begin m_w1[n] = p_w1[n]; m_t1[n] = int'(p_t1[n]); end
    for (int k = 0; k < N_OUT; k++) begin m_w2[k] = p_w2[k]; m_t2[k] = int'(p_t2[k][2:0]); end
  endtask

  task automatic pend_fixed();
    for (int n = 0; n < N_HID; n++) begin p_w1[n] = 8'hF0; p_t1[n] = 4'd5; end
    for (int k = 0; k < N_OUT; k++) begin p_w2[k] = 4'hF; p_t2[k] = 4'd4; end
  endtask

  task automatic pend_random();
    for (int n = 0; n < N_HID; n++) begin
      p_w1[n] = 8'($urandom);
      p_t1[n] = 4'($urandom_range(0, 9));
    end
    for (int k = 0; k < N_OUT; k++) begin
      p_w2[k] = 4'($urandom);
      p_t2[k] = 4'($urandom);
    end
  endtask

  // Records: L1 = w[3:0], w[7:4], thr ; L2 = w[3:0], thr (top threshold bit is excess).
  task automatic build_stream();
    stream.delete();
    for (int n = 0; n < N_HID; n++) begin
      stream.push_back(p_w1[n][3:0]);
      stream.push_back(p_w1[n][7:4]);
      stream.push_back(p_t1[n]);
    end
    for (int k = 0; k < N_OUT; k++) begin
      stream.push_back(p_w2[k]);
      stream.push_back(p_t2[k]);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_en = 1'b0; cfg_nib = '0; out_ready = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_cfg_done", 32'(cfg_done), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Streams stream[first .. stop-1]; stop_at < 0 means the whole stream.
  task automatic do_cfg(input int first, input int pause_at, input int pause_len, input int stop_at);
    int last;
    last = (stop_at >= 0) ? stop_at : stream.size();
    for (int i = first; i < last; i++) begin
      if (i == pause_at) begin
        cfg_en = 1'b0;
        repeat (pause_len) begin
          @(posedge clk); #1;
          check("cfg_pause_busy", 32'(busy), 32'(1));
          check("cfg_pause_done", 32'(cfg_done), 32'(0));
        end
      end
      cfg_en = 1'b1;
      cfg_nib = stream[i];
      @(posedge clk); #1;
      check("cfg_done", 32'(cfg_done), 32'(i == stream.size() - 1));
      check("cfg_busy", 32'(busy), 32'(i != stream.size() - 1));
    end
    cfg_en = 1'b0;
    if (stop_at < 0) begin
      @(posedge clk); #1;
      check("cfg_done_one_cycle", 32'(cfg_done), 32'(0));
    end
  endtask

  task automatic send_vec(input logic [IN_W-1:0] x, input bit bp);
    int waited;
    waited = 0;
    while (!in_ready && waited < 100) begin
      if (bp) out_ready = 1'($urandom);
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", waited);
      return;
    end
    exp_q.push_back(model_out(x));
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
    if (bp) out_ready = 1'($urandom);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
    check("drain_idle_valid", 32'(out_valid), 32'(0));
    check("drain_idle_busy", 32'(busy), 32'(0));
  endtask

  // Monitor: compares each output at the handshake against the oldest expected value.
  initial begin
    logic [N_OUT-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h with no vector pending at t=%0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IN_W-1:0]  x;
    logic [N_OUT-1:0] hold_exp;
    int               waited;

    // Scenario 1: reset values, latency with the all-zero configuration.
    apply_reset();
    exp_q.push_back(model_out(8'h00));
    check("s1_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h5A;
    check("s1_busy_l1", 32'(busy), 32'(1));
    check("s1_valid_t0", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("s1_valid_t1", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("s1_valid_t2", 32'(out_valid), 32'(1));
    check("s1_out_data", 32'(out_data), 32'(4'hF));
    @(posedge clk); #1;
    check("s1_valid_after", 32'(out_valid), 32'(0));
    check("s1_in_ready_after", 32'(in_ready), 32'(1));

    // Scenario 2: fixed config, known vectors.
    pend_fixed(); build_stream();
    do_cfg(0, -1, 0, -1);
    model_commit();
    send_vec(8'hF0, 1'b0);
    send_vec(8'h0F, 1'b0);
    drain();

    // Scenario 3: backpressure holds output; cfg nibbles during OUT are dropped.
    x = IN_W'($urandom);
    hold_exp = model_out(x);
    out_ready = 1'b0;
    send_vec(x, 1'b0);
    waited = 0;
    while (!out_valid && waited < 10) begin @(posedge clk); #1; waited++; end
    check("s3_valid", 32'(out_valid), 32'(1));
    for (int c = 0; c < 5; c++) begin
      check("s3_hold_valid", 32'(out_valid), 32'(1));
      check("s3_hold_data", 32'(out_data), 32'(hold_exp));
      check("s3_hold_in_ready", 32'(in_ready), 32'(0));
      cfg_en = (c == 1 || c == 2);
      cfg_nib = 4'h5;
      @(posedge clk); #1;
    end
    cfg_en = 1'b0;
    check("s3_cfg_done_quiet", 32'(cfg_done), 32'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("s3_release_in_ready", 32'(in_ready), 32'(1));
    check("s3_release_valid", 32'(out_valid), 32'(0));
    send_vec(8'hF0, 1'b0);
    send_vec(8'h3C, 1'b0);
    drain();

    // Scenario 5: cfg_en beats in_valid in IDLE; then random traffic on a random config.
    pend_random(); build_stream();
    in_valid = 1'b1; in_data = 8'hAA;
    cfg_en = 1'b1; cfg_nib = stream[0];
    #1;
    check("s5_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("s5_busy_cfg", 32'(busy), 32'(1));
    do_cfg(1, -1, 0, -1);
    model_commit();
    check("s5_no_output", 32'(out_valid), 32'(0));
    for (int v = 0; v < 30; v++) send_vec(IN_W'($urandom), 1'b1);
    drain();

    // Scenario 4: paused config mid-record yields the same fixed-config behaviour.
    apply_reset();
    pend_fixed(); build_stream();
    do_cfg(0, 1, 3, -1);
    model_commit();
    send_vec(8'hF0, 1'b0);
    send_vec(8'h0F, 1'b0);
    for (int v = 0; v < 5; v++) send_vec(IN_W'($urandom), 1'b0);
    drain();

    // Scenario 6: reset after 7 nibbles discards everything; a fresh config starts at L1[0].
    pend_random(); build_stream();
    do_cfg(0, -1, 0, 7);
    apply_reset();
    send_vec(8'h00, 1'b0);
    send_vec(IN_W'($urandom), 1'b0);
    drain();
    pend_random(); build_stream();
    do_cfg(0, -1, 0, -1);
    model_commit();
    for (int v = 0; v < 30; v++) send_vec(IN_W'($urandom), 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
